// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer: serial TDM demux (in: clk, rst, din, en, sync; out: Y, valid, slot, frame_err, par_err); define TDM_DEMUX_PARITY_EN for a 9th even-parity slot
module tdm_demultiplexer (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       en,
  input  logic       sync,
  output logic [7:0] Y,
  output logic       valid,
  output logic [3:0] slot,
  output logic       frame_err,
  output logic       par_err
);
`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [3:0] LAST = 4'd8;
  localparam int NB = 8;
`else
  localparam logic [3:0] LAST = 4'd7;
  localparam int NB = 7;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state;
  logic [NB-1:0] r_buf;
  logic [7:0] r_y;
  logic [3:0] r_slot;
  logic r_valid, r_frame_err, r_par_err;
  logic w_resync;
  assign w_resync = en && sync && (r_state == IDLE || r_slot != 4'd0);
  assign Y = r_y;
  assign valid = r_valid;
  assign slot = r_slot;
  assign frame_err = r_frame_err;
  assign par_err = r_par_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_buf <= '0;
      r_y <= 8'h00;
      r_slot <= 4'd0;
      r_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err <= 1'b0;
      if (w_resync) begin
        r_buf[0] <= din;
        r_slot <= 4'd1;
        r_state <= RUN;
        r_frame_err <= r_state == RUN;
      end else if (en && r_state == RUN) begin
        if (r_slot == LAST) begin
          r_slot <= 4'd0;
`ifdef TDM_DEMUX_PARITY_EN
          if (^{r_buf, din})
            r_par_err <= 1'b1;
          else begin
            r_y <= r_buf;
            r_valid <= 1'b1;
          end
`else
          r_y <= {din, r_buf};
          r_valid <= 1'b1;
`endif
        end else begin
          r_buf[r_slot[2:0]] <= din;
          r_slot <= r_slot + 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_tdm_demultiplexer.sv
// tb_tdm_demultiplexer: table vectors, corner sequences and a random run against a bit-queue reference model
module tb_tdm_demultiplexer;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NS = 9;
`else
  localparam int NS = 8;
`endif
  logic clk = 0, rst = 1, din = 0, en = 0, sync = 0;
  logic [7:0] Y;
  logic valid, frame_err, par_err;
  logic [3:0] slot;
  tdm_demultiplexer dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
    .Y(Y), .valid(valid), .slot(slot), .frame_err(frame_err), .par_err(par_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic en, sync, din;
    logic [7:0] y;
    logic v;
    logic [3:0] s;
    logic fe, pe;
  } vec_t;
  vec_t tbl[$];
  int tests = 0, fails = 0, cyc = 0, last_v = 0, prev_v = 0;
  bit m_run = 0;
  bit q[$];
  logic [7:0] m_y = 8'h00;
  logic m_v, m_fe, m_pe;
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic model_reset();
    m_run = 0;
    q.delete();
    m_y = 8'h00;
  endtask
  task automatic step(input logic e, input logic s, input logic d);
    logic [7:0] w;
    en = e; sync = s; din = d;
    @(posedge clk); #1;
    cyc++;
    m_v = 0; m_fe = 0; m_pe = 0;
    if (e && s) begin
      m_fe = m_run && q.size() != 0;
      q.delete();
      q.push_back(d);
      m_run = 1;
    end else if (e && m_run) begin
      q.push_back(d);
      if (q.size() == NS) begin
        for (int k = 0; k < 8; k++) w[k] = q[k];
        if (NS == 9 && ((^w) != q[8])) m_pe = 1;
        else begin
          m_y = w;
          m_v = 1;
        end
        q.delete();
      end
    end
    chk("model_Y", Y, m_y);
    chk("model_valid", {7'd0, valid}, {7'd0, m_v});
    chk("model_slot", {4'd0, slot}, 8'(q.size()));
    chk("model_frame_err", {7'd0, frame_err}, {7'd0, m_fe});
    chk("model_par_err", {7'd0, par_err}, {7'd0, m_pe});
    if (valid) begin
      prev_v = last_v;
      last_v = cyc;
    end
  endtask
  function automatic void add(input logic e, s, d, input logic [7:0] y, input logic v,
                              input logic [3:0] sl, input logic fe, pe);
    vec_t r;
    r.en = e; r.sync = s; r.din = d; r.y = y; r.v = v; r.s = sl; r.fe = fe; r.pe = pe;
    tbl.push_back(r);
  endfunction
  function automatic void fill(input logic [7:0] w, input logic pbit, input logic [7:0] yb, input logic fe0);
    logic b[$];
    logic ok, last;
    for (int k = 0; k < 8; k++) b.push_back(w[k]);
    if (NS == 9) b.push_back(pbit);
    ok = (NS == 8) || ((^w) == pbit);
    for (int i = 0; i < NS; i++) begin
      last = i == NS - 1;
      add(1, i == 0, b[i], (last && ok) ? w : yb, last && ok, last ? 4'd0 : 4'(i + 1), i == 0 && fe0, last && !ok);
    end
  endfunction
  task automatic send_bits(input logic [7:0] w, input int from, input int to);
    for (int k = from; k <= to; k++) step(1, k == 0, k < 8 ? w[k] : ^w);
  endtask
  initial begin
    int n;
    fill(8'h4D, 1'b0, 8'h00, 0);
    add(0, 0, 1, 8'h4D, 0, 4'd0, 0, 0);
    fill(8'h4D, 1'b1, 8'h4D, 0);
    for (int i = 0; i < 5; i++) add(1, i == 0, 1, 8'h4D, 0, 4'(i + 1), 0, 0);
    fill(8'h55, 1'b0, 8'h4D, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_Y", Y, 8'h00);
    chk("reset_valid", {7'd0, valid}, 8'd0);
    chk("reset_slot", {4'd0, slot}, 8'd0);
    chk("reset_frame_err", {7'd0, frame_err}, 8'd0);
    chk("reset_par_err", {7'd0, par_err}, 8'd0);
    rst = 0;
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].sync, tbl[i].din);
      chk($sformatf("vec%0d_Y", i), Y, tbl[i].y);
      chk($sformatf("vec%0d_valid", i), {7'd0, valid}, {7'd0, tbl[i].v});
      chk($sformatf("vec%0d_slot", i), {4'd0, slot}, {4'd0, tbl[i].s});
      chk($sformatf("vec%0d_frame_err", i), {7'd0, frame_err}, {7'd0, tbl[i].fe});
      chk($sformatf("vec%0d_par_err", i), {7'd0, par_err}, {7'd0, tbl[i].pe});
    end
    send_bits(8'hA5, 0, NS - 1);
    chk("b2b_Y0", Y, 8'hA5);
    send_bits(8'h3C, 0, NS - 1);
    chk("b2b_Y1", Y, 8'h3C);
    chk("b2b_spacing", 8'(last_v - prev_v), 8'(NS));
    n = cyc;
    send_bits(8'hF0, 0, 4);
    repeat (3) begin
      step(0, 0, 1);
      chk("stall_slot", {4'd0, slot}, 8'd5);
    end
    send_bits(8'hF0, 5, NS - 1);
    chk("stall_Y", Y, 8'hF0);
    chk("stall_latency", 8'(last_v - n), 8'(NS + 3));
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 1);
    #3 rst = 1;
    #1;
    chk("midrst_Y", Y, 8'h00);
    chk("midrst_valid", {7'd0, valid}, 8'd0);
    chk("midrst_slot", {4'd0, slot}, 8'd0);
    chk("midrst_frame_err", {7'd0, frame_err}, 8'd0);
    chk("midrst_par_err", {7'd0, par_err}, 8'd0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    n = 0;
    repeat (8) begin
      step(1, 0, 1'($urandom % 2));
      n += int'(valid);
    end
    chk("nosync_valids", 8'(n), 8'd0);
    repeat (800) step(($urandom % 10) < 8, ($urandom % 12) == 0, 1'($urandom % 2));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tdm_demultiplexer.md
# tdm_demultiplexer

Serial-to-parallel time-division demultiplexer: the receive end of the 8:1 selector path. The transmit side drives one bit per slot with its 3-bit select; this block tracks the slot, steers each incoming bit to its output position, and publishes the reassembled 8-bit word with a one-cycle valid strobe. A sync input aligns slot 0, and misaligned sync is flagged as a framing error.

## Interface
- Parameters: none; word width is fixed at 8 slots.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  1  serial data bit for the current slot
- en  input  1  slot strobe; one slot consumed per cycle with en=1
- sync  input  1  marks the current din as slot 0; sampled only when en=1
- Y  output  8  last complete word; Y[k] = bit received in slot k
- valid  output  1  one-cycle pulse when Y is updated
- slot  output  4  index of the next slot expected; bit 3 is 0 unless parity is compiled in
- frame_err  output  1  one-cycle pulse on sync at a nonzero slot
- par_err  output  1  one-cycle parity failure pulse; constant 0 unless parity is compiled in

## Operation
- Reset values: Y=8'h00, valid=0, slot=0, frame_err=0, par_err=0, internal buffer=0, state IDLE.
- States: IDLE (unaligned, waiting for sync) and RUN (aligned).
- IDLE, en=1, sync=1: buf[0]<=din, slot<=1, go to RUN.
- IDLE, en=1, sync=0: din is discarded and slot stays 0.
- RUN, en=1, sync=0: buf[slot]<=din, slot<=slot+1.
- Final data slot 7: Y<={din, buf[6:0]}, valid<=1, slot wraps to 0, state stays RUN.
- RUN, en=1, sync=1, slot=0: this is a normal slot-0 capture and raises no error.
- RUN, en=1, sync=1, slot≠0: frame_err<=1, and the partial word is discarded. buf[0]<=din and slot<=1 (resynchronize). Y is not updated.
- en=0: all state holds, and valid, frame_err and par_err are 0 that cycle.
- The buffer is not cleared between words. Y changes only when valid pulses.
- Reset asserted mid-word: all outputs and state return to reset values immediately, the partial word is lost, and the block re-enters IDLE.

## Timing
- valid, frame_err, par_err, Y and slot are all registered and change only on the clk edge, or asynchronously on rst.
- Latency: valid and the new Y are visible in the cycle after the edge that samples slot 7 (or the parity slot). The last input bit reaches Y in 1 cycle.
- Throughput: back-to-back words with en held high produce one valid pulse every 8 cycles, or every 9 cycles with parity.
- valid and frame_err are never both high in the same cycle.

## Configuration
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Each frame has 9 slots; slot 8 carries an even-parity bit over the 8 data bits.
  - The 8 data bits are staged internally and slot counts 0..8.
  - On the slot-8 capture: if ^{data, din}==0, then Y<=data and valid<=1; otherwise par_err<=1 and Y is unchanged.
  - slot wraps 8→0.
- Undefined: frames have 8 slots, slot[3]=0 always, and par_err is tied 0.

## Test plan
- Reset: assert rst mid-stream with en=1 → Y=00, valid=0, slot=0 and all error flags 0 in the same cycle. After release, 8 en cycles without sync → no valid.
- Basic word: sync on slot 0, then din bits 1,0,1,1,0,0,1,0 (slots 0..7) → Y=8'h4D, a single valid pulse one cycle after the slot-7 edge, slot back to 0.
- Back-to-back: continuous en with 8'hA5 then 8'h3C (sync on each slot 0) → two valid pulses exactly 8 cycles apart, Y=A5 then 3C, no frame_err.
- Stall: 8'hF0 with en deasserted for 3 cycles after slot 4 → slot holds at 5 during the stall, then Y=F0 with valid 3 cycles later than the unstalled case.
- Misaligned sync: sync at slot 5 → frame_err pulse, slot=1 next cycle, Y unchanged. The following 7 bits complete the new word, and valid shows it.
- Parity (TDM_DEMUX_PARITY_EN defined):
  - 8'h4D with parity bit 0 → valid, Y=4D.
  - The same word with parity bit 1 → par_err pulse, no valid, Y holds the previous value.
